nn_convnode_mc: RTL

- Multi-channel successor to the single-output stochastic convolution node.
- Takes one N-bit stochastic input window and drives M output channels. Each channel has its own signed weights and bias.
- Each channel integrates the signed stochastic sum in a saturating up/down accumulator and regenerates an output bitstream against a shared random word. ACT_MODE selects ReLU or linear activation.
- Every WINDOW enabled cycles, all accumulators are snapshotted to a valid/ready port for readout or training logic.

---
 rtl/nn_convnode_mc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/nn_convnode_mc.sv
// rtl/nn_convnode_mc.sv - multi-channel stochastic convolution node with windowed snapshot port
module nn_convnode_mc #(
    parameter int N        = 4,
    parameter int M        = 2,
    parameter int ACC_W    = 8,
    parameter int WINDOW   = 16,
    parameter int ACT_MODE = 0,
    parameter int SNAP_CLR = 0
) (
    input  logic                 CLK,
    input  logic                 INIT_N,
    input  logic                 EN,
    input  logic                 CLR,
    input  logic [N-1:0]         a,
    input  logic                 d,
    input  logic [M*N-1:0]       alpha,
    input  logic [M*N-1:0]       SIGN_alpha,
    input  logic [M-1:0]         beta,
    input  logic [M-1:0]         SIGN_beta,
    input  logic [ACC_W-2:0]     r,
    output logic [M-1:0]         z,
    output logic [M-1:0]         SIGN_z,
    output logic [M-1:0]         zp,
    output logic [M-1:0]         a_out,
    output logic [M*ACC_W-1:0]   snap_data,
    output logic                 snap_valid,
    input  logic                 snap_ready,
    output logic                 snap_ovf
);
    // delta spans -(N+2)..+(N+1); SW leaves one guard bit above both operands
    localparam int DW      = $clog2(N + 3) + 1;
    localparam int SW      = ((ACC_W > DW) ? ACC_W : DW) + 1;
    localparam int CW      = $clog2(WINDOW);
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam logic signed [SW-1:0] SAT_HI = SW'(ACC_MAX);
    localparam logic signed [SW-1:0] SAT_LO = -SW'(ACC_MAX);

    logic [DW-1:0]           pos     [M];
    logic [DW-1:0]           neg     [M];
    logic signed [DW-1:0]    delta   [M];
    logic signed [SW-1:0]    sum     [M];
    logic signed [ACC_W-1:0] acc     [M];
    logic signed [ACC_W-1:0] acc_upd [M];
    logic signed [ACC_W-1:0] acc_abs [M];
    logic [ACC_W-2:0]        mag     [M];
    logic [CW-1:0]           cnt;
    logic                    wrap;

    // the enabled edge that closes a window captures the snapshot
    assign wrap = EN & ~CLR & (cnt == CW'(WINDOW - 1));

    // per-channel signed delta, saturated update candidate and magnitude of the held acc
    always_comb begin
        for (int m = 0; m < M; m++) begin
            pos[m] = {{(DW-1){1'b0}}, beta[m] & ~SIGN_beta[m]};
            neg[m] = {{(DW-1){1'b0}}, beta[m] &  SIGN_beta[m]};
            for (int n = 0; n < N; n++) begin
                pos[m] = pos[m] + {{(DW-1){1'b0}}, a[n] & alpha[m*N+n] & ~SIGN_alpha[m*N+n]};
                neg[m] = neg[m] + {{(DW-1){1'b0}}, a[n] & alpha[m*N+n] &  SIGN_alpha[m*N+n]};
            end
            delta[m] = $signed(pos[m] - neg[m] - {{(DW-1){1'b0}}, d});
            sum[m]   = SW'(acc[m]) + SW'(delta[m]);
            if (sum[m] > SAT_HI) begin
                acc_upd[m] = SAT_HI[ACC_W-1:0];
            end else if (sum[m] < SAT_LO) begin
                acc_upd[m] = SAT_LO[ACC_W-1:0];
            end else begin
                acc_upd[m] = sum[m][ACC_W-1:0];
            end
            // symmetric saturation keeps the most-negative code out, so |acc| fits ACC_W-1 bits
            acc_abs[m] = acc[m][ACC_W-1] ? -acc[m] : acc[m];
            mag[m]     = acc_abs[m][ACC_W-2:0];
        end
    end

    // accumulators and window counter advance only on enabled cycles
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            cnt <= '0;
            for (int m = 0; m < M; m++) acc[m] <= '0;
        end else if (CLR) begin
            cnt <= '0;
            for (int m = 0; m < M; m++) acc[m] <= '0;
        end else if (EN) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            for (int m = 0; m < M; m++) acc[m] <= (wrap && SNAP_CLR != 0) ? '0 : acc_upd[m];
        end
    end

    // regenerated streams and activation, refreshed every cycle from the registered acc
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            z      <= '0;
            SIGN_z <= '0;
            zp     <= '0;
            a_out  <= '0;
        end else begin
            for (int m = 0; m < M; m++) begin
                z[m]      <= (mag[m] > r);
                SIGN_z[m] <= acc[m][ACC_W-1];
                if (ACT_MODE == 0) begin
                    a_out[m] <= (mag[m] > r) & ~acc[m][ACC_W-1];
                    zp[m]    <= ~acc[m][ACC_W-1];
                end else begin
                    a_out[m] <= (mag[m] > r);
                    zp[m]    <= 1'b1;
                end
            end
        end
    end

    // snapshot register with valid/ready handshake and sticky overwrite flag
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            snap_data  <= '0;
            snap_valid <= 1'b0;
            snap_ovf   <= 1'b0;
        end else if (CLR) begin
            snap_valid <= 1'b0;
            snap_ovf   <= 1'b0;
        end else if (wrap) begin
            for (int m = 0; m < M; m++) snap_data[m*ACC_W +: ACC_W] <= acc_upd[m];
            snap_valid <= 1'b1;
            if (snap_valid && !snap_ready) snap_ovf <= 1'b1;
        end else if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
        end
    end
endmodule
